ddr3_frame_wr_ctrl: RTL

Consumer stage between the MJPEG packing buffer and the DDR3 controller user interface. On each buffer-ready request it reads the announced rank of 128-bit words from port B of the write dual-port buffer, writes them to DDR3 at the current frame write pointer, and acknowledges. At frame end it reports the frame's DDR3 base address and byte length, then advances to the next frame slot in a ring of slots.

---
 rtl/ddr3_frame_wr_ctrl_if.sv | 44 ++++
 rtl/ddr3_frame_wr_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_frame_wr_ctrl_if.sv
// Bundle of the buffer-request, DPB port B, DDR3 user-interface and
// frame-report signals of the DDR3 frame write controller.
// The master view belongs to the controller; the slave view belongs to its environment.
interface ddr3_frame_wr_ctrl_if;
  logic         i_wr_req;
  logic         i_wr_frame_down;
  logic [1:0]   i_wr_buf_rank;
  logic [6:0]   i_wr_buf_128cnt;
  logic [5:0]   i_wr_buf_Bytecnt;
  logic         o_wr_down;
  logic [9:0]   o_dpb_wr_b_addr;
  logic         o_dpb_wr_b_ce;
  logic [63:0]  i_dpb_wr_b_rd_data;
  logic         i_init_calib_complete;
  logic [2:0]   o_app_cmd;
  logic         o_app_cmd_en;
  logic [27:0]  o_app_addr;
  logic         i_app_cmd_rdy;
  logic [127:0] o_app_wdata;
  logic         o_app_wdata_en;
  logic         o_app_wdata_end;
  logic [15:0]  o_app_wdata_mask;
  logic         i_app_wdata_rdy;
  logic         o_frame_valid;
  logic [27:0]  o_frame_base_addr;
  logic [23:0]  o_frame_len_byte;
  logic         o_frame_overflow;

  modport master (
    input  i_wr_req, i_wr_frame_down, i_wr_buf_rank, i_wr_buf_128cnt, i_wr_buf_Bytecnt,
           i_dpb_wr_b_rd_data, i_init_calib_complete, i_app_cmd_rdy, i_app_wdata_rdy,
    output o_wr_down, o_dpb_wr_b_addr, o_dpb_wr_b_ce, o_app_cmd, o_app_cmd_en, o_app_addr,
           o_app_wdata, o_app_wdata_en, o_app_wdata_end, o_app_wdata_mask,
           o_frame_valid, o_frame_base_addr, o_frame_len_byte, o_frame_overflow
  );

  modport slave (
    output i_wr_req, i_wr_frame_down, i_wr_buf_rank, i_wr_buf_128cnt, i_wr_buf_Bytecnt,
           i_dpb_wr_b_rd_data, i_init_calib_complete, i_app_cmd_rdy, i_app_wdata_rdy,
    input  o_wr_down, o_dpb_wr_b_addr, o_dpb_wr_b_ce, o_app_cmd, o_app_cmd_en, o_app_addr,
           o_app_wdata, o_app_wdata_en, o_app_wdata_end, o_app_wdata_mask,
           o_frame_valid, o_frame_base_addr, o_frame_len_byte, o_frame_overflow
  );
endinterface

// File: rtl/ddr3_frame_wr_ctrl.sv
// DDR3 frame write controller: drains one rank of 128-bit words from the
// write DPB (as two 64-bit halves) into DDR3 at the current slot offset,
// acknowledges the rank, and reports base/length/overflow at frame end
// before moving to the next slot of the ring.
module ddr3_frame_wr_ctrl #(
  parameter logic [6:0]  UDP_FRAME_MAX_SIZE_128 = 7'd91,
  parameter logic [27:0] FRAME_SLOT_SIZE        = 28'h0100000,
  parameter int          SLOT_BITS              = 2
) (
  input  logic                 i_pclk,
  input  logic                 i_rst,
  ddr3_frame_wr_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_H, RD_L, CAP_H, CAP_L, WR, DONE} state_t;

  state_t               state;
  logic [1:0]           rank_r;
  logic [6:0]           cnt_r;
  logic [5:0]           bytecnt_r;
  logic                 fd_r;
  logic [6:0]           idx;
  logic [SLOT_BITS-1:0] slot_idx;
  logic [27:0]          offset;
  logic [23:0]          len_acc;
  logic                 ovf_r;
  logic                 skip_r;
  logic                 cmd_done;
  logic                 data_done;

  logic         wr_down, dpb_ce, cmd_en, wdata_en, frame_valid, frame_ovf;
  logic [9:0]   dpb_addr;
  logic [27:0]  app_addr, frame_base;
  logic [127:0] wdata;
  logic [23:0]  frame_len;

  // A rank larger than the buffer can hold is clamped to the buffer size.
  function automatic logic [6:0] sat_cnt(input logic [6:0] c);
    return (c > UDP_FRAME_MAX_SIZE_128) ? UDP_FRAME_MAX_SIZE_128 : c;
  endfunction

  // Bytes contributed by one rank; the final rank's last word carries only bc bytes.
  function automatic logic [23:0] rank_bytes(input logic [6:0] c, input logic [5:0] bc,
                                             input logic fd);
    if (c == 7'd0) return 24'd0;
    if (fd) return {13'd0, c - 7'd1, 4'd0} + {18'd0, bc};
    return {13'd0, c, 4'd0};
  endfunction

  logic [6:0]  acc_cnt, d_cnt;
  logic [5:0]  d_bc;
  logic        d_fd;
  logic        accept, cmd_hs, data_hs, wr_fin, last_word, go_done, word_ovf;
  logic [23:0] rank_len;
  logic [27:0] slot_base;

  assign acc_cnt   = sat_cnt(bus.i_wr_buf_128cnt);
  assign accept    = (state == IDLE) && bus.i_wr_req && bus.i_init_calib_complete;
  assign cmd_hs    = cmd_en && bus.i_app_cmd_rdy;
  assign data_hs   = wdata_en && bus.i_app_wdata_rdy;
  assign wr_fin    = (cmd_done || cmd_hs || skip_r) && (data_done || data_hs || skip_r);
  assign last_word = (idx == cnt_r - 7'd1);
  assign go_done   = (accept && (acc_cnt == 7'd0)) ||
                     ((state == WR) && wr_fin && last_word);
  // An empty rank goes straight to DONE from IDLE, before its fields are registered.
  assign d_cnt     = (state == IDLE) ? acc_cnt : cnt_r;
  assign d_bc      = (state == IDLE) ? bus.i_wr_buf_Bytecnt : bytecnt_r;
  assign d_fd      = (state == IDLE) ? bus.i_wr_frame_down : fd_r;
  assign rank_len  = rank_bytes(d_cnt, d_bc, d_fd);
  assign word_ovf  = ({1'b0, offset} + 29'd8) > {1'b0, FRAME_SLOT_SIZE};
  assign slot_base = 28'(slot_idx) * FRAME_SLOT_SIZE;

  // Sequencer: DPB read of both halves, DDR3 write handshake, rank and frame bookkeeping.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      rank_r      <= '0;
      cnt_r       <= '0;
      bytecnt_r   <= '0;
      fd_r        <= 1'b0;
      idx         <= '0;
      slot_idx    <= '0;
      offset      <= '0;
      len_acc     <= '0;
      ovf_r       <= 1'b0;
      skip_r      <= 1'b0;
      cmd_done    <= 1'b0;
      data_done   <= 1'b0;
      wr_down     <= 1'b0;
      dpb_ce      <= 1'b0;
      dpb_addr    <= '0;
      cmd_en      <= 1'b0;
      wdata_en    <= 1'b0;
      app_addr    <= '0;
      wdata       <= '0;
      frame_valid <= 1'b0;
      frame_ovf   <= 1'b0;
      frame_base  <= '0;
      frame_len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rank_r    <= bus.i_wr_buf_rank;
            cnt_r     <= acc_cnt;
            bytecnt_r <= bus.i_wr_buf_Bytecnt;
            fd_r      <= bus.i_wr_frame_down;
            idx       <= '0;
            dpb_addr  <= {bus.i_wr_buf_rank, 7'd0, 1'b0};
            dpb_ce    <= (acc_cnt != 7'd0);
            state     <= (acc_cnt == 7'd0) ? DONE : RD_H;
          end
        end
        RD_H: begin
          dpb_addr <= {rank_r, idx, 1'b1};
          state    <= RD_L;
        end
        RD_L: begin
          dpb_ce <= 1'b0;
          state  <= CAP_H;
        end
        CAP_H: begin
          wdata[127:64] <= bus.i_dpb_wr_b_rd_data;
          state         <= CAP_L;
        end
        CAP_L: begin
          wdata[63:0] <= bus.i_dpb_wr_b_rd_data;
          app_addr    <= slot_base + offset;
          skip_r      <= word_ovf;
          cmd_en      <= !word_ovf;
          wdata_en    <= !word_ovf;
          if (word_ovf) ovf_r <= 1'b1;
          state       <= WR;
        end
        WR: begin
          if (cmd_hs) begin
            cmd_en   <= 1'b0;
            cmd_done <= 1'b1;
          end
          if (data_hs) begin
            wdata_en  <= 1'b0;
            data_done <= 1'b1;
          end
          if (wr_fin) begin
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
            if (!skip_r) offset <= offset + 28'd8;
            if (last_word) begin
              state <= DONE;
            end else begin
              idx      <= idx + 7'd1;
              dpb_addr <= {rank_r, idx + 7'd1, 1'b0};
              dpb_ce   <= 1'b1;
              state    <= RD_H;
            end
          end
        end
        DONE: begin
          wr_down     <= 1'b0;
          frame_valid <= 1'b0;
          frame_ovf   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (go_done) begin
        wr_down <= 1'b1;
        if (d_fd) begin
          frame_valid <= 1'b1;
          frame_base  <= slot_base;
          frame_len   <= len_acc + rank_len;
          frame_ovf   <= ovf_r;
          slot_idx    <= slot_idx + SLOT_BITS'(1);
          offset      <= '0;
          len_acc     <= '0;
          ovf_r       <= 1'b0;
        end else begin
          len_acc <= len_acc + rank_len;
        end
      end
    end
  end

  assign bus.o_wr_down         = wr_down;
  assign bus.o_dpb_wr_b_addr   = dpb_addr;
  assign bus.o_dpb_wr_b_ce     = dpb_ce;
  assign bus.o_app_cmd         = 3'b000;
  assign bus.o_app_cmd_en      = cmd_en;
  assign bus.o_app_addr        = app_addr;
  assign bus.o_app_wdata       = wdata;
  assign bus.o_app_wdata_en    = wdata_en;
  assign bus.o_app_wdata_end   = wdata_en;
  assign bus.o_app_wdata_mask  = 16'h0000;
  assign bus.o_frame_valid     = frame_valid;
  assign bus.o_frame_base_addr = frame_base;
  assign bus.o_frame_len_byte  = frame_len;
  assign bus.o_frame_overflow  = frame_ovf;

endmodule
